// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the round controller,
// round datapath and key schedule.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_BLK_W = 128;
   localparam int AES_RND_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_e;

   typedef logic [AES_NR:0][AES_BLK_W-1:0] rkeys_t;

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (b[i] ? aa : 8'h00);
         aa = gf_xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as the affine map of the field inverse x^254 (0 maps to 0).
   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
      return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
   endfunction

   function automatic rkeys_t aes_expand_key(input logic [AES_BLK_W-1:0] key);
      logic [31:0] w [0:4*AES_NR+3];
      logic [31:0] t;
      logic [7:0]  rcon;
      rkeys_t      rk;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) begin
         w[i] = key[AES_BLK_W-1-32*i -: 32];
      end
      for (int i = 4; i < 4*AES_NR+4; i++) begin
         t = w[i-1];
         if ((i % 4) == 0) begin
            t    = aes_sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
            rcon = gf_xtime(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= AES_NR; r++) begin
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      return rk;
   endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational AES-128 key schedule; returns the round key selected by round.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] key,
   input  logic [AES_RND_W-1:0] round,
   output logic [AES_BLK_W-1:0] rkey
);

   rkeys_t rk_s;

   // Expand the cipher key and pick the round key; indices past NR give zero.
   always_comb begin
      rk_s = aes_expand_key(key);
      if (round <= AES_RND_W'(AES_NR)) begin
         rkey = rk_s[round];
      end else begin
         rkey = '0;
      end
   end

endmodule

// File: rtl/aes_round_dp.sv
// Combinational AES encryption round: round 0 is the initial addRoundKey,
// the last round skips mixColumns.
module aes_round_dp
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] state,
   input  logic [AES_RND_W-1:0] round,
   input  logic                 last,
   input  logic [AES_BLK_W-1:0] rkey,
   output logic [AES_BLK_W-1:0] result
);

   logic [7:0]           sb_s [0:15];
   logic [7:0]           sr_s [0:15];
   logic [7:0]           mc_s [0:15];
   logic [AES_BLK_W-1:0] mixed_s;

   // Byte 0 is the most significant byte; bytes are column-major (byte 4c+r is row r, col c).
   always_comb begin
      mixed_s = '0;
      for (int i = 0; i < 16; i++) begin
         sb_s[i] = aes_sbox(state[AES_BLK_W-1-8*i -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc_s[4*c]   = gf_xtime(sr_s[4*c]) ^ gf_xtime(sr_s[4*c+1]) ^ sr_s[4*c+1]
                     ^ sr_s[4*c+2] ^ sr_s[4*c+3];
         mc_s[4*c+1] = sr_s[4*c] ^ gf_xtime(sr_s[4*c+1]) ^ gf_xtime(sr_s[4*c+2])
                     ^ sr_s[4*c+2] ^ sr_s[4*c+3];
         mc_s[4*c+2] = sr_s[4*c] ^ sr_s[4*c+1] ^ gf_xtime(sr_s[4*c+2])
                     ^ gf_xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
         mc_s[4*c+3] = gf_xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c+1]
                     ^ sr_s[4*c+2] ^ gf_xtime(sr_s[4*c+3]);
      end
      for (int i = 0; i < 16; i++) begin
         mixed_s[AES_BLK_W-1-8*i -: 8] = last ? sr_s[i] : mc_s[i];
      end
      if (round == 4'd0) begin
         result = state ^ rkey;
      end else begin
         result = mixed_s ^ rkey;
      end
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: loads a block, steps the external round
// datapath through rounds 0..NR and hands the ciphertext out on valid/ready.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR     = AES_NR,
   parameter int DATA_W = AES_BLK_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_text,
   input  logic                 key_valid,
   input  logic                 abort,
   output logic [AES_RND_W-1:0] dp_round,
   output logic                 dp_last,
   output logic [DATA_W-1:0]    dp_state,
   input  logic [DATA_W-1:0]    dp_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_text,
   output logic                 busy
);

   localparam logic [AES_RND_W-1:0] LAST_RND = AES_RND_W'(NR);
   localparam logic [AES_RND_W-1:0] PRE_LAST = AES_RND_W'(NR - 1);

   ctrl_state_e          state_r;
   logic [AES_RND_W-1:0] round_r;
   logic                 last_r;
   logic                 busy_r;
   logic                 out_valid_r;
   logic [DATA_W-1:0]    blk_r;
   logic [DATA_W-1:0]    out_text_r;
   logic                 in_ready_s;
   logic                 accept_s;

   // Acceptance window; held low while reset is asserted so reset outputs read idle.
   always_comb begin
      in_ready_s = 1'b0;
      if (rst_n && key_valid && !abort) begin
         case (state_r)
            IDLE:    in_ready_s = 1'b1;
            DONE:    in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
         endcase
      end else begin
         in_ready_s = 1'b0;
      end
   end

   assign accept_s = in_valid && in_ready_s;

   // Controller FSM; round_r is zero outside RUN so it drives dp_round directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         round_r     <= '0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         blk_r       <= '0;
         out_text_r  <= '0;
      end else if (abort) begin
         state_r     <= IDLE;
         round_r     <= '0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  blk_r   <= in_text;
                  round_r <= '0;
                  last_r  <= (LAST_RND == 4'd0);
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end
            end
            RUN: begin
               blk_r <= dp_result;
               if (round_r == LAST_RND) begin
                  out_text_r  <= dp_result;
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  round_r     <= '0;
                  last_r      <= 1'b0;
                  state_r     <= DONE;
               end else begin
                  round_r <= round_r + 4'd1;
                  last_r  <= (round_r == PRE_LAST);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (accept_s) begin
                     blk_r   <= in_text;
                     round_r <= '0;
                     last_r  <= (LAST_RND == 4'd0);
                     busy_r  <= 1'b1;
                     state_r <= RUN;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               round_r     <= '0;
               last_r      <= 1'b0;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign dp_round  = round_r;
   assign dp_last   = last_r;
   assign dp_state  = blk_r;
   assign out_valid = out_valid_r;
   assign out_text  = out_text_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl wired to the round datapath and key schedule,
// scored against published AES-128 known-answer vectors.
module tb_aes_round_ctrl;
   import aes_pkg::*;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_S0  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CT_S0  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] PT_S1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] CT_S1  = 128'hf5d3d58503b9699de785895a96fdbaaf;
   localparam logic [127:0] PT_S2  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
   localparam logic [127:0] CT_S2  = 128'h43b1cd7f598ece23881b00e3ed030688;

   logic         clk, rst_n, in_valid, in_ready, key_valid, abort;
   logic         dp_last, out_valid, out_ready, busy;
   logic [127:0] in_text, dp_state, dp_result, out_text, key, rkey;
   logic [3:0]   dp_round;

   int           total, bad;
   logic [127:0] exp_q [$];

   aes_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_text(in_text), .key_valid(key_valid), .abort(abort),
      .dp_round(dp_round), .dp_last(dp_last), .dp_state(dp_state),
      .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_text(out_text), .busy(busy)
   );

   aes_key_expand u_key (.key(key), .round(dp_round), .rkey(rkey));

   aes_round_dp u_dp (
      .state(dp_state), .round(dp_round), .last(dp_last), .rkey(rkey), .result(dp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_block(input logic [127:0] pt, input logic [127:0] ct);
      @(posedge clk); #1;
      in_text  = pt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(ct);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; key_valid = 1'b1; in_valid = 1'b0; abort = 1'b0;
      out_ready = 1'b0; in_text = '0; key = KEY_C1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (dp_round !== 4'd0 || dp_last !== 1'b0) begin bad++; $display("FAIL rst_dp_round got=%0d/%b want=0/0", dp_round, dp_last); end
      total++; if (dp_state !== 128'd0 || out_text !== 128'd0) begin bad++; $display("FAIL rst_data got=%h/%h want=0/0", dp_state, out_text); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_fips;
      logic [127:0] e;
      int busy_cnt;
      key = KEY_C1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_text = PT_C1; in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fips_in_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(CT_C1);
      busy_cnt = 0;
      total++; if (dp_state !== PT_C1) begin bad++; $display("FAIL fips_dp_state0 got=%h want=%h", dp_state, PT_C1); end
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         total++;
         if (dp_round !== 4'(k) || dp_last !== 1'(k == 10) || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL fips_trace k=%0d got round=%0d last=%b ov=%b want round=%0d last=%b ov=0",
                     k, dp_round, dp_last, out_valid, k, (k == 10));
         end
         if (busy) busy_cnt++;
      end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL fips_latency got ov=%b busy=%b want ov=1 busy=0", out_valid, busy); end
      total++; if (busy_cnt != 11) begin bad++; $display("FAIL fips_busy_cycles got=%0d want=11", busy_cnt); end
      total++;
      if (exp_q.size() == 0) begin
         bad++; $display("FAIL fips_text got=%h want=<none queued>", out_text);
      end else begin
         e = exp_q.pop_front();
         if (out_text !== e) begin bad++; $display("FAIL fips_text got=%h want=%h", out_text, e); end
      end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fips_retire got=%b want=0", out_valid); end
   endtask

   task automatic test_backpressure;
      logic [127:0] e;
      int n;
      key = KEY_B; out_ready = 1'b0;
      send_block(PT_B, CT_B);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got ov=%b want=1", out_valid); end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      in_valid = 1'b1; in_text = PT_C1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (out_valid !== 1'b1 || out_text !== e || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold i=%0d got ov=%b text=%h rdy=%b want ov=1 text=%h rdy=0",
                     i, out_valid, out_text, in_ready, e);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", out_valid); end
   endtask

   task automatic test_back_to_back;
      logic [127:0] pts [3];
      logic [127:0] cts [3];
      logic [127:0] e;
      int acc_cyc [3];
      int idx, got, cyc;
      logic acc;
      pts[0] = PT_S0; pts[1] = PT_S1; pts[2] = PT_S2;
      cts[0] = CT_S0; cts[1] = CT_S1; cts[2] = CT_S2;
      key = KEY_B; out_ready = 1'b1;
      idx = 0; got = 0; cyc = 0;
      in_text = pts[0]; in_valid = 1'b1;
      while (got < 3 && cyc < 80) begin
         #1;
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            exp_q.push_back(cts[idx]);
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 3) in_text = pts[idx];
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL b2b_text got=%h want=<none queued>", out_text);
            end else begin
               e = exp_q.pop_front();
               if (out_text !== e) begin bad++; $display("FAIL b2b_text blk=%0d got=%h want=%h", got, out_text, e); end
            end
            got++;
         end
      end
      in_valid = 1'b0;
      total++; if (got != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got); end
      total++;
      if (idx != 3 || acc_cyc[1] - acc_cyc[0] != 12 || acc_cyc[2] - acc_cyc[1] != 12) begin
         bad++;
         $display("FAIL b2b_spacing got accepts=%0d gaps=%0d,%0d want 3 gaps=12,12",
                  idx, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
   endtask

   task automatic test_abort;
      logic [127:0] e;
      logic [127:0] dropped;
      int n;
      logic saw;
      key = KEY_C1; out_ready = 1'b1;
      send_block(PT_C1, CT_C1);
      n = 0;
      while (dp_round != 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (dp_round !== 4'd5) begin bad++; $display("FAIL abort_reach got=%0d want=5", dp_round); end
      abort = 1'b1; in_valid = 1'b1; in_text = PT_B;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b want=0", in_ready); end
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      if (exp_q.size() != 0) dropped = exp_q.pop_back();
      total++;
      if (busy !== 1'b0 || dp_round !== 4'd0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL abort_idle got busy=%b round=%0d ov=%b want 0/0/0", busy, dp_round, out_valid);
      end
      total++; if (out_text !== CT_S2) begin bad++; $display("FAIL abort_keep_text got=%h want=%h", out_text, CT_S2); end
      saw = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid || busy) saw = 1'b1;
      end
      total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_quiet got activity=%b want=0", saw); end
      send_block(PT_C1, CT_C1);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++;
      if (!out_valid || exp_q.size() == 0) begin
         bad++; $display("FAIL abort_next got ov=%b want=1", out_valid);
      end else begin
         e = exp_q.pop_front();
         if (out_text !== e) begin bad++; $display("FAIL abort_next got=%h want=%h", out_text, e); end
      end
   endtask

   task automatic test_async_reset;
      logic [127:0] e;
      int n;
      key = KEY_B; out_ready = 1'b1;
      send_block(PT_B, CT_B);
      n = 0;
      while (dp_round != 4'd3 && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (dp_round !== 4'd3) begin bad++; $display("FAIL arst_reach got=%0d want=3", dp_round); end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || dp_round !== 4'd0 ||
          dp_last !== 1'b0 || dp_state !== 128'd0 || out_text !== 128'd0) begin
         bad++;
         $display("FAIL arst_outputs got rdy=%b ov=%b busy=%b round=%0d last=%b st=%h txt=%h want all 0",
                  in_ready, out_valid, busy, dp_round, dp_last, dp_state, out_text);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      key_valid = 1'b0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL keyinv_in_ready got=%b want=0", in_ready); end
      key_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL keyok_in_ready got=%b want=1", in_ready); end
      send_block(PT_S0, CT_S0);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++;
      if (!out_valid || exp_q.size() == 0) begin
         bad++; $display("FAIL arst_next got ov=%b want=1", out_valid);
      end else begin
         e = exp_q.pop_front();
         if (out_text !== e) begin bad++; $display("FAIL arst_next got=%h want=%h", out_text, e); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset;
      test_fips;
      test_backpressure;
      test_back_to_back;
      test_abort;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
